// File: rtl/operand_entry_pkg.sv
// Shared definitions for the calculator operand-entry block:
// key codes, FSM state type and the elaboration width check.
package operand_entry_pkg;

  localparam logic [3:0] KEY_ENTER     = 4'd10;
  localparam logic [3:0] KEY_CLEAR     = 4'd11;
  localparam logic [3:0] KEY_BACKSPACE = 4'd12;

  typedef enum logic {
    ST_ENTRY,
    ST_OFFER
  } state_t;

  // True when 10^max_digits - 1 is representable in width bits.
  function automatic bit max_digits_fit(int width, int max_digits);
    logic [255:0] lim;
    lim = 256'd1;
    for (int i = 0; i < max_digits; i++)
      lim = lim * 256'd10;
    lim = lim - 256'd1;
    if (width >= 256) return 1'b1;
    return (lim >> width) == 256'd0;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Keypad press detector: registers key_valid and emits a one-cycle
// press pulse, one clock after the rising edge is sampled.
// Ports: clk, rst_n (sync, active-low), key_valid in, press out.
module key_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic key_valid,
  output logic press
);

  logic key_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q <= 1'b0;
      press <= 1'b0;
    end else begin
      key_q <= key_valid;
      press <= key_valid & ~key_q;
    end
  end

endmodule

// File: rtl/operand_entry.sv
// Decimal operand entry: keypad digits accumulate as acc*10+d and each
// finished operand is offered to the ALU over a valid/ready handshake.
// Ports: clk, rst_n (sync, active-low), key_valid/key_code in;
// acc, digit_count, full, reject display/status out;
// op_valid/op_data/op_index out, op_ready in.
// Optional: OPERAND_ENTRY_BACKSPACE_EN enables BACKSPACE (acc/10).
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int MAX_DIGITS   = 4,
  parameter int WIDTH        = 32,
  parameter int NUM_OPERANDS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_valid,
  input  logic [3:0] key_code,
  output logic [WIDTH-1:0] acc,
  output logic [$clog2(MAX_DIGITS+1)-1:0] digit_count,
  output logic full,
  output logic reject,
  output logic op_valid,
  output logic [WIDTH-1:0] op_data,
  output logic [(NUM_OPERANDS > 1 ? $clog2(NUM_OPERANDS) : 1)-1:0] op_index,
  input  logic op_ready
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int IW = NUM_OPERANDS > 1 ? $clog2(NUM_OPERANDS) : 1;

  if (!max_digits_fit(WIDTH, MAX_DIGITS)) begin : g_fit_check
    $error("operand_entry: 10^MAX_DIGITS-1 does not fit in WIDTH");
  end

  state_t state;
  logic press;
  logic [3:0] code_q;

  key_edge_detect u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .press     (press)
  );

  logic [WIDTH+3:0] mac;
  assign mac = {4'd0, acc} * (WIDTH+4)'(10)
             + {{WIDTH{1'b0}}, code_q};

  logic is_digit, is_enter, is_clear;
  assign is_digit = code_q < 4'd10;
  assign is_enter = code_q == KEY_ENTER;
  assign is_clear = code_q == KEY_CLEAR;

`ifdef OPERAND_ENTRY_BACKSPACE_EN
  // Exact floor(x/10) for any WIDTH-bit x:
  // m = floor(2^(W+4)/10)+1, q = (x*m) >> (W+4).
  localparam logic [WIDTH+4:0] DIV_POW = {1'b1, {(WIDTH+4){1'b0}}};
  localparam logic [WIDTH+4:0] DIV_M =
    DIV_POW / (WIDTH+5)'(10) + (WIDTH+5)'(1);

  logic is_bksp;
  logic [2*WIDTH+4:0] div_prod;
  logic [WIDTH-1:0] acc_div;
  assign is_bksp  = code_q == KEY_BACKSPACE;
  assign div_prod = {{(WIDTH+5){1'b0}}, acc}
                  * {{WIDTH{1'b0}}, DIV_M};
  assign acc_div  = WIDTH'(div_prod >> (WIDTH+4));
`endif

  assign full = digit_count == CW'(MAX_DIGITS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_ENTRY;
      acc         <= '0;
      digit_count <= '0;
      reject      <= 1'b0;
      op_valid    <= 1'b0;
      op_data     <= '0;
      op_index    <= '0;
      code_q      <= '0;
    end else begin
      code_q <= key_code;
      reject <= 1'b0;
      unique case (state)
        ST_ENTRY: begin
          if (press) begin
            unique case (1'b1)
              is_digit: begin
                if (digit_count < CW'(MAX_DIGITS)) begin
                  acc         <= WIDTH'(mac);
                  digit_count <= digit_count + 1'b1;
                end else begin
                  reject <= 1'b1;
                end
              end
              is_enter: begin
                if (digit_count != '0) begin
                  op_data  <= acc;
                  op_valid <= 1'b1;
                  state    <= ST_OFFER;
                end else begin
                  reject <= 1'b1;
                end
              end
              is_clear: begin
                acc         <= '0;
                digit_count <= '0;
                op_index    <= '0;
              end
`ifdef OPERAND_ENTRY_BACKSPACE_EN
              is_bksp: begin
                if (digit_count != '0) begin
                  acc         <= acc_div;
                  digit_count <= digit_count - 1'b1;
                end else begin
                  reject <= 1'b1;
                end
              end
`endif
              default: ;
            endcase
          end
        end
        ST_OFFER: begin
          // Keypad is locked while an operand waits for the ALU.
          if (press)
            reject <= 1'b1;
          if (op_ready) begin
            op_valid    <= 1'b0;
            acc         <= '0;
            digit_count <= '0;
            state       <= ST_ENTRY;
            if (op_index == IW'(NUM_OPERANDS - 1))
              op_index <= '0;
            else
              op_index <= op_index + 1'b1;
          end
        end
        default: state <= ST_ENTRY;
      endcase
    end
  end

endmodule

// File: doc/operand_entry.md
# operand_entry

Parametrised decimal operand-entry block for the calculator datapath. It turns keypad strobes into multi-digit unsigned operands through a digit-shift accumulator, where each digit does acc = acc*10 + d. It collects up to NUM_OPERANDS operands in sequence and hands each one to the ALU through a valid/ready handshake. It sits between the keypad decoder and the arithmetic unit, and drives the display with the live accumulator.

## Interface
- MAX_DIGITS, default 4, is the maximum decimal digits per operand.
- WIDTH, default 32, is the accumulator and operand width. Elaboration fails if 10^MAX_DIGITS − 1 does not fit in WIDTH bits.
- NUM_OPERANDS, default 2, is the number of operands per calculation.
- clk, input, 1: the single system clock.
- rst_n, input, 1: reset, synchronous and active-low.
- key_valid, input, 1: key-held level from the keypad decoder. A press is detected internally on its rising edge.
- key_code, input, 4: key identity, sampled in the rising-edge cycle. 0–9 are digits, 10 is ENTER, 11 is CLEAR, 12 is BACKSPACE, and 13–15 are ignored.
- acc, output, WIDTH: live accumulator for the display.
- digit_count, output, $clog2(MAX_DIGITS+1): digits currently entered.
- full, output, 1: high when digit_count == MAX_DIGITS.
- reject, output, 1: one-cycle pulse when a press is refused.
- op_valid, output, 1: an operand is being offered.
- op_data, output, WIDTH: the offered operand.
- op_index, output, $clog2(NUM_OPERANDS) (min 1): slot number of the offered or next operand.
- op_ready, input, 1: the ALU accepts the operand when op_valid && op_ready.

## Operation
- Press event: key_valid & ~key_q, where key_q is key_valid registered. A held key produces exactly one event.
- The FSM has two states, ENTRY and OFFER. Reset enters ENTRY.
- ENTRY, digit d:
  - When count < MAX_DIGITS, acc ← acc*10 + d and count += 1.
  - Otherwise the press is refused: reject pulses and acc is unchanged.
  - Leading zeros count as digits.
- ENTRY, ENTER:
  - When count > 0, op_data ← acc, op_valid ← 1, and the FSM goes to OFFER.
  - When count == 0, reject pulses.
- ENTRY, CLEAR: acc, count and op_index all go to 0.
- ENTRY, BACKSPACE: handled as described under Configuration.
- ENTRY, codes 13–15: ignored, with no reject pulse.
- OFFER:
  - Every press event is ignored and pulses reject.
  - op_valid and op_data stay stable until op_valid && op_ready. Then op_valid ← 0, acc ← 0, count ← 0, and op_index increments; it wraps to 0 after NUM_OPERANDS−1. The FSM returns to ENTRY.
- Arithmetic: acc*10 + d is computed in WIDTH+4 bits and truncated. It never overflows because of the elaboration check.

## Timing
- Reset values: acc=0, digit_count=0, full=0, reject=0, op_valid=0, op_data=0, op_index=0, key_q=0.
- Reset mid-operation, including during OFFER with op_valid high, returns everything to the reset values on the next clk edge.
- A key_valid rising edge sampled at clk edge N updates acc, count, reject and op_valid at edge N+1 (one-cycle latency).
- Handshake: a transfer completes at the edge where op_valid && op_ready. op_valid is low in the following cycle. There is no combinational path from op_ready to op_valid.
- If op_ready is already high when ENTER registers, the transfer happens at the next edge, so op_valid is high for exactly one cycle.
- A press event in the same cycle as a transfer is ignored with a reject pulse, because the FSM is in OFFER during that cycle.
- reject lasts one cycle per refused event.

## Configuration
- OPERAND_ENTRY_BACKSPACE_EN defined:
  - BACKSPACE in ENTRY with count > 0 does acc ← acc/10 and count −= 1.
  - With count == 0 it pulses reject.
  - Divide-by-10 uses a constant-divisor multiply-shift; no iterative divider.
- Not defined: code 12 is treated like codes 13–15 (ignored, no reject) and no divider logic is built.

## Structure
- Shared package operand_entry_pkg holds:
  - key code constants KEY_ENTER=4'd10, KEY_CLEAR=4'd11, KEY_BACKSPACE=4'd12;
  - state enum state_t {ST_ENTRY, ST_OFFER};
  - the function max_digits_fit(WIDTH, MAX_DIGITS) used by the elaboration check.
- One sub-module, key_edge_detect: registers key_valid and outputs a one-cycle press pulse. The stopwatch keypad path reuses it.

## Test plan
- Keys 1, 2, 3, ENTER with op_ready=1 → acc passes through 1, 12, 123; op_valid is high for one cycle with op_data=123 and op_index=0; op_index is then 1 and acc is 0.
- With MAX_DIGITS=4, keys 9, 9, 9, 9, 9 → acc=9999, full=1, and one reject pulse on the fifth digit.
- Keys 4, 5, ENTER with op_ready=0 for 5 cycles → op_valid and op_data=45 are held; digit 7 pressed during OFFER pulses reject; raising op_ready transfers 45.
- Operand 7 then operand 8 accepted (NUM_OPERANDS=2) → op_index goes 0, 1, 0. ENTER with no digits → reject, op_valid stays 0.
- With the macro defined, keys 5, 6, BACKSPACE, BACKSPACE, BACKSPACE → acc goes 56, 5, 0 and the third BACKSPACE pulses reject. Without the macro, acc stays 56 and there is no reject.
- Keys 3, 1, ENTER, then rst_n=0 for one cycle while op_valid=1 → all outputs return to 0. key_valid held high for 10 cycles produces exactly one digit.
